// File: rtl/seg7_pkg.sv
// Shared types and active-high segment constants for the 7-segment scan driver.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with a load-strobed shadow of the BCD digits.
// Optional leading-zero blanking: define SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned COMMON_ANODE = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [4*DIGITS-1:0]                            bcd_in,
    input  logic                                           load,
    output logic [6:0]                                     seg,
    output logic [DIGITS-1:0]                              an,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx
);

    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
    localparam bit          INVERT = (COMMON_ANODE != 0);

    localparam logic [6:0]        SEG_OFF = INVERT ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = INVERT ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] shadow_q;
    logic [4*DIGITS-1:0] shadow_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    idx_d;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   an_d;
    logic [DIGITS-1:0]   blank_mask;
    logic                wrap;
    bcd_t                cur_digit;
    logic                cur_blank;
    logic [6:0]          dec_seg;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic zero_above;

    // Blank every digit whose own value and all higher digits are zero; digit 0 never blanks
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_above    = zero_above && (shadow_q[4*k +: 4] == 4'd0);
            blank_mask[k] = zero_above;
        end
    end
`else
    assign blank_mask = '0;
`endif

    // Select the shadow digit addressed by the current scan index
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_digit = shadow_q[4*k +: 4];
                cur_blank = blank_mask[k];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg_c (dec_seg)
    );

    // Next-state: refresh counter, scan index, shadow capture and output patterns
    always_comb begin
        wrap     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d    = digit_idx;
        shadow_d = load ? bcd_in : shadow_q;
        seg_d    = cur_blank ? SEG_BLANK : dec_seg;
        an_d     = '0;
        if (wrap) begin
            idx_d = (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end
        for (int k = 0; k < int'(DIGITS); k++) begin
            an_d[k] = (digit_idx == IDX_W'(k));
        end
        if (INVERT) begin
            seg_d = ~seg_d;
            an_d  = ~an_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            cnt_q     <= '0;
            digit_idx <= '0;
            seg       <= SEG_OFF;
            an        <= AN_OFF;
        end else begin
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            digit_idx <= idx_d;
            seg       <= seg_d;
            an        <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: common-anode and common-cathode instances, REFRESH_DIV=4.
module tb_seg7_scan_driver;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = 16'h0000;

    logic [6:0] seg_ca, seg_cc;
    logic [3:0] an_ca, an_cc;
    logic [1:0] idx_ca, idx_cc;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(1)) u_dut_ca (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .load      (load),
        .seg       (seg_ca),
        .an        (an_ca),
        .digit_idx (idx_ca)
    );

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .COMMON_ANODE(0)) u_dut_cc (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .load      (load),
        .seg       (seg_cc),
        .an        (an_cc),
        .digit_idx (idx_cc)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    localparam logic [6:0] BLK_CA = 7'h7F;
    localparam logic [6:0] BLK_CC = 7'h00;
`else
    localparam logic [6:0] BLK_CA = 7'h40;
    localparam logic [6:0] BLK_CC = 7'h3F;
`endif

    typedef struct {
        int         cyc;
        bit         dut;
        logic [6:0] seg;
        logic [3:0] an;
        bit         chk_idx;
        logic [1:0] idx;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void push_range(int c0, int c1, bit dut, logic [6:0] s, logic [3:0] a, string tag);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.cyc = c; e.dut = dut; e.seg = s; e.an = a;
            e.chk_idx = 1'b0; e.idx = 2'd0; e.tag = tag;
            sb.push_back(e);
        end
    endfunction

    function automatic void push_idx(int c, bit dut, logic [6:0] s, logic [3:0] a, logic [1:0] i, string tag);
        exp_t e;
        e.cyc = c; e.dut = dut; e.seg = s; e.an = a;
        e.chk_idx = 1'b1; e.idx = i; e.tag = tag;
        sb.push_back(e);
    endfunction

    task automatic check(string name, int c, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, c, act, exp);
    endtask

    task automatic wait_edge(int n);
        while (cyc_cnt < n) @(negedge clk);
    endtask

    // Monitor: compare every expectation due on this cycle, away from the rising edge
    initial begin
        exp_t       e;
        logic [6:0] s;
        logic [3:0] a;
        logic [1:0] i;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
                e = sb.pop_front();
                if (e.cyc < cyc_cnt) begin
                    n_checks++;
                    $display("FAIL %s missed: due cyc=%0d now=%0d", e.tag, e.cyc, cyc_cnt);
                end else begin
                    s = e.dut ? seg_cc : seg_ca;
                    a = e.dut ? an_cc  : an_ca;
                    i = e.dut ? idx_cc : idx_ca;
                    check({e.tag, ".seg"}, e.cyc, {1'b0, s}, {1'b0, e.seg});
                    check({e.tag, ".an"},  e.cyc, {4'h0, a}, {4'h0, e.an});
                    if (e.chk_idx) check({e.tag, ".idx"}, e.cyc, {6'h0, i}, {6'h0, e.idx});
                end
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc_cnt);
        $fatal(1);
    end

    initial begin
        // Hand-computed expectations, common anode unless noted, in cycle order
        push_idx(1, 0, 7'h7F, 4'hF, 2'd0, "reset");
        push_idx(2, 0, 7'h7F, 4'hF, 2'd0, "reset");
        push_idx(3, 0, 7'h7F, 4'hF, 2'd0, "reset");
        push_idx(4, 0, 7'h40, 4'hE, 2'd0, "first_after_reset");
        push_range(5, 7,   0, 7'h19, 4'hE, "v1234_d0");
        push_idx(8, 0, 7'h30, 4'hD, 2'd1, "v1234_d1");
        push_range(9, 11,  0, 7'h30, 4'hD, "v1234_d1");
        push_range(12, 15, 0, 7'h24, 4'hB, "v1234_d2");
        push_range(16, 19, 0, 7'h79, 4'h7, "v1234_d3");
        push_range(20, 23, 0, 7'h19, 4'hE, "v1234_repeat_d0");
        push_range(24, 26, 0, 7'h30, 4'hD, "noload_hold_d1");
        push_idx(27, 0, 7'h30, 4'hD, 2'd2, "wrap_load_d1");
        push_range(28, 31, 0, 7'h02, 4'hB, "v5678_d2");
        push_range(32, 35, 0, 7'h12, 4'h7, "v5678_d3");
        push_range(36, 39, 0, 7'h00, 4'hE, "v5678_d0");
        push_range(40, 43, 0, 7'h3F, 4'hD, "vA0F9_d1_dash");
        push_range(44, 47, 0, 7'h40, 4'hB, "vA0F9_d2_zero");
        push_range(48, 51, 0, 7'h3F, 4'h7, "vA0F9_d3_dash");
        push_range(52, 55, 0, 7'h10, 4'hE, "vA0F9_d0_nine");
        push_range(56, 59, 0, 7'h12, 4'hD, "v0050_d1");
        push_range(60, 63, 0, BLK_CA, 4'hB, "v0050_d2_lead");
        push_range(64, 67, 0, BLK_CA, 4'h7, "v0050_d3_lead");
        push_range(68, 71, 0, 7'h40, 4'hE, "v0050_d0");
        push_range(72, 75, 0, BLK_CA, 4'hD, "v0000_d1");
        push_range(76, 79, 0, BLK_CA, 4'hB, "v0000_d2");
        push_range(80, 83, 0, BLK_CA, 4'h7, "v0000_d3");
        push_range(84, 87, 0, 7'h40, 4'hE, "v0000_d0");
        push_range(88, 91, 0, BLK_CA, 4'hD, "v0000_d1b");
        push_idx(92, 0, BLK_CA, 4'hB, 2'd2, "ca_pre_rst_d2");
        push_idx(92, 1, BLK_CC, 4'h4, 2'd2, "cc_pre_rst_d2");
        push_idx(93, 0, 7'h7F, 4'hF, 2'd0, "ca_midscan_rst");
        push_idx(93, 1, 7'h00, 4'h0, 2'd0, "cc_midscan_rst");
        push_idx(94, 0, 7'h40, 4'hE, 2'd0, "ca_after_rst");
        push_idx(94, 1, 7'h3F, 4'h1, 2'd0, "cc_after_rst");
        push_range(95, 96, 1, 7'h3F, 4'h1, "cc_after_rst_hold");

        // Stimulus: inputs change at the falling edge after the named rising edge
        wait_edge(3);
        rst = 1'b0; load = 1'b1; bcd_in = 16'h1234;
        wait_edge(4);
        load = 1'b0;
        wait_edge(23);
        bcd_in = 16'h5678;
        wait_edge(26);
        load = 1'b1;
        wait_edge(27);
        load = 1'b0;
        wait_edge(38);
        bcd_in = 16'hA0F9; load = 1'b1;
        wait_edge(39);
        load = 1'b0;
        wait_edge(54);
        bcd_in = 16'h0050; load = 1'b1;
        wait_edge(55);
        load = 1'b0;
        wait_edge(70);
        bcd_in = 16'h0000; load = 1'b1;
        wait_edge(71);
        load = 1'b0;
        wait_edge(92);
        rst = 1'b1; load = 1'b1; bcd_in = 16'h8888;
        wait_edge(93);
        rst = 1'b0; load = 1'b0;
        wait_edge(100);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s never checked: due cyc=%0d", e.tag, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
